// File: rtl/uart_tx_feeder_if.sv
// Host write port and uart_master launch/done signals of the transmit feeder.
// master = host/transmitter side, slave = the feeder itself.
interface uart_tx_feeder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_en;
    logic                  tx_done;
    logic                  busy;
    logic                  overflow;
    logic                  timeout_err;
    logic                  clr_err;

    modport master (
        output wr_en, wr_data, tx_done, clr_err,
        input  full, empty, count, tx_data, tx_en, busy, overflow, timeout_err
    );

    modport slave (
        input  wr_en, wr_data, tx_done, clr_err,
        output full, empty, count, tx_data, tx_en, busy, overflow, timeout_err
    );
endinterface

// File: rtl/uart_tx_feeder.sv
// FIFO-buffered launcher for uart_master: pops one byte, strobes tx_en, waits
// for tx_done (or a watchdog), idles GAP_CYCLES, then launches the next byte.
module uart_tx_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int DEPTH          = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_feeder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr, rptr;
    logic [CW-1:0]         count;
    logic [GW-1:0]         gap_cnt;
    logic [TW-1:0]         wdog;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_en, overflow, timeout_err;
    logic                  full, empty, push, pop, ovf_evt, to_evt;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push    = bus.wr_en && !full;
    assign ovf_evt = bus.wr_en && full;
    assign pop     = (state == IDLE) && !empty;
    // tx_done has priority over the watchdog in the same cycle
    assign to_evt  = (state == WAIT) && !bus.tx_done && (TIMEOUT_CYCLES != 0) &&
                     (wdog == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            gap_cnt     <= '0;
            wdog        <= '0;
            tx_data     <= '0;
            tx_en       <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow    <= (overflow && !bus.clr_err) || ovf_evt;
            timeout_err <= (timeout_err && !bus.clr_err) || to_evt;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        tx_data <= mem[rptr];
                        tx_en   <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    tx_en <= 1'b0;
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // a timed-out byte counts as consumed; no retry
                    if (bus.tx_done || to_evt) begin
                        gap_cnt <= GW'(GAP_CYCLES - 1);
                        state   <= (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        wdog <= wdog + TW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - GW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.count       = count;
    assign bus.tx_data     = tx_data;
    assign bus.tx_en       = tx_en;
    assign bus.busy        = (state != IDLE);
    assign bus.overflow    = overflow;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Random and directed stimulus for uart_tx_feeder, checked every cycle against
// a queue-and-timestamp model of the launch schedule.
module tb_uart_tx_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;
    localparam int TO    = 32;
    localparam int BIG   = 1 << 30;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resp_done = 1'b0;
    logic man_done  = 1'b0;
    int   mode = 0;            // 0 stalled, 1 clean done, 2 done plus noise
    int   checks = 0, failures = 0;

    uart_tx_feeder_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.tx_done = resp_done | man_done;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // model: queue of bytes plus the cycle at which the launcher is next free
    int       cyc = 0, free_at = 0, wait_start = 0, last_done = -1;
    bit       waiting = 0;
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_tx_data = '0;
    bit       exp_tx_en = 0, exp_busy = 0, exp_ovf = 0, exp_terr = 0;
    bit       m_full, m_pop, m_ovf, m_to;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            free_at = cyc + 1; waiting = 0;
            exp_tx_en = 0; exp_tx_data = '0; exp_ovf = 0; exp_terr = 0;
        end else begin
            m_full = (mq.size() == DEPTH);
            m_pop  = (cyc >= free_at) && (mq.size() != 0);
            m_ovf  = bus.wr_en && m_full;
            m_to   = 0;
            if (waiting && cyc >= wait_start) begin
                if (bus.tx_done) begin
                    free_at = cyc + GAP + 1; waiting = 0; last_done = cyc;
                end else if (TO != 0 && cyc == wait_start + TO - 1) begin
                    m_to = 1; free_at = cyc + GAP + 1; waiting = 0;
                end
            end
            if (m_pop) begin
                exp_tx_data = mq.pop_front();
                waiting = 1; wait_start = cyc + 2; free_at = BIG;
            end
            if (bus.wr_en && !m_full) mq.push_back(bus.wr_data);
            exp_tx_en = m_pop;
            exp_ovf   = (exp_ovf && !bus.clr_err) || m_ovf;
            exp_terr  = (exp_terr && !bus.clr_err) || m_to;
        end
        exp_busy = (cyc + 1) < free_at;
        cyc++;
    end

    // per-cycle compare plus launch log
    bit chk_en = 0, chk_spacing = 0;
    int last_launch = -1;
    logic [DW-1:0] log_q[$];
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("count",       32'(bus.count),   32'(mq.size()));
            chk("full",        32'(bus.full),    32'(mq.size() == DEPTH));
            chk("empty",       32'(bus.empty),   32'(mq.size() == 0));
            chk("tx_en",       32'(bus.tx_en),   32'(exp_tx_en));
            chk("tx_data",     32'(bus.tx_data), 32'(exp_tx_data));
            chk("busy",        32'(bus.busy),    32'(exp_busy));
            chk("overflow",    32'(bus.overflow),    32'(exp_ovf));
            chk("timeout_err", 32'(bus.timeout_err), 32'(exp_terr));
            if (bus.tx_en && chk_spacing && last_done >= 0)
                chk("launch_spacing", 32'(cyc), 32'(last_done + GAP + 2));
        end
        if (bus.tx_en) begin
            log_q.push_back(bus.tx_data);
            last_launch = cyc;
        end
    end

    // transmitter stand-in
    int rcnt = 0;
    always @(negedge clk) begin
        resp_done = 1'b0;
        if (rst || mode == 0) rcnt = 0;
        else begin
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) resp_done = 1'b1;
            end
            if (bus.tx_en) rcnt = $urandom_range(1, 5);
            if (mode == 2 && $urandom_range(0, 15) == 0) resp_done = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic write1(input logic [DW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((bus.busy || !bus.empty) && n < bound) begin step(); n++; end
        chk("drain_in_bound", 32'(n < bound), 32'd1);
    endtask

    task automatic wait_launch(input string nm, input int bound);
        int n = 0;
        while (!bus.tx_en && n < bound) begin step(); n++; end
        chk(nm, 32'(bus.tx_en), 32'd1);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL global_timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_data = '0; bus.clr_err = 1'b0;
        step(); chk_en = 1; step();
        rst = 1'b0;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full",  32'(bus.full),  0);
        chk("rst_tx_en", 32'(bus.tx_en), 0);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_flags", 32'({bus.overflow, bus.timeout_err}), 0);

        // single byte: tx_en two cycles after the write cycle
        mode = 1;
        write1(8'hA5);
        chk("a5_no_early_launch", 32'(bus.tx_en), 0);
        step();
        chk("a5_launch", 32'(bus.tx_en), 1);
        chk("a5_data", 32'(bus.tx_data), 32'h A5);
        chk("a5_count", 32'(bus.count), 0);
        wait_idle(100);

        // five back-to-back bytes, spacing measured from each tx_done
        log_q.delete(); last_done = -1; chk_spacing = 1;
        for (int i = 1; i <= 5; i++) write1(DW'(i));
        wait_idle(200);
        chk_spacing = 0;
        chk("burst_len", 32'(log_q.size()), 5);
        for (int i = 0; i < 5 && i < log_q.size(); i++) chk("burst_order", 32'(log_q[i]), 32'(i + 1));
        chk("burst_busy_end", 32'(bus.busy), 0);

        // stalled transmitter: fill, overflow, clear, then watchdog
        mode = 0;
        for (int i = 0; i < 17; i++) write1(DW'(8'h10 + i));
        chk("stall_count", 32'(bus.count), 16);
        chk("stall_full",  32'(bus.full), 1);
        chk("stall_no_ovf", 32'(bus.overflow), 0);
        write1(8'hEE);
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 16);
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 0);
        begin
            int n = 0;
            while (!bus.timeout_err && n < 100) begin step(); n++; end
        end
        chk("timeout_set", 32'(bus.timeout_err), 1);
        chk("timeout_cycle", 32'(cyc), 32'(last_launch + 1 + TO));
        wait_launch("after_timeout_launch", 10);
        chk("after_timeout_data", 32'(bus.tx_data), 32'h11);
        mode = 1;
        bus.clr_err = 1'b1; step(); bus.clr_err = 1'b0;
        chk("timeout_clr", 32'(bus.timeout_err), 0);
        wait_idle(3000);

        // write and pop in the same cycle with three entries stored
        mode = 0;
        write1(8'h30);
        wait_launch("sc_launch", 10);
        for (int i = 1; i <= 3; i++) write1(DW'(8'h30 + i));
        chk("sc_pre_count", 32'(bus.count), 3);
        man_done = 1'b1; step(); man_done = 1'b0;
        begin
            int n = 0;
            while (bus.busy && n < 10) begin step(); n++; end
        end
        chk("sc_idle_count", 32'(bus.count), 3);
        mode = 1;
        write1(8'h34);
        chk("sc_same_cycle_count", 32'(bus.count), 3);
        chk("sc_launch2", 32'(bus.tx_en), 1);
        wait_idle(500);

        // 40 sequential bytes through the wrapping pointers, noisy tx_done
        mode = 2; log_q.delete();
        for (int i = 0; i < 40; ) begin
            if (!bus.full && $urandom_range(0, 2) != 0) begin
                bus.wr_en = 1'b1; bus.wr_data = DW'(i); i++;
            end
            step();
            bus.wr_en = 1'b0;
        end
        wait_idle(3000);
        chk("seq_len", 32'(log_q.size()), 40);
        for (int i = 0; i < 40 && i < log_q.size(); i++) chk("seq_order", 32'(log_q[i]), 32'(i));

        // random traffic with occasional clears and resets
        for (int i = 0; i < 1500; i++) begin
            bus.wr_en   = ($urandom_range(0, 2) == 0);
            bus.wr_data = DW'($urandom);
            bus.clr_err = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            step();
        end
        bus.wr_en = 1'b0; bus.clr_err = 1'b0; rst = 1'b0;
        mode = 1;
        wait_idle(3000);

        // reset while waiting for tx_done with four bytes queued
        mode = 0; log_q.delete();
        for (int i = 0; i < 5; i++) write1(DW'(8'h50 + i));
        step(); step();
        chk("rst_wait_busy", 32'(bus.busy), 1);
        chk("rst_wait_count", 32'(bus.count), 4);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstw_count", 32'(bus.count), 0);
        chk("rstw_empty", 32'(bus.empty), 1);
        chk("rstw_tx_en", 32'(bus.tx_en), 0);
        chk("rstw_busy",  32'(bus.busy),  0);
        man_done = 1'b1; step(); man_done = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("rstw_no_relaunch", 32'(log_q.size()), 1);
        chk("rstw_still_idle",  32'(bus.busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
